// File: rtl/ram_shim_pkg.sv
// Shared definitions for the RAM stream shims: FSM state encoding and
// constant helper functions used to size buffers, counters and indices.
package ram_shim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ram_addr_wrap.sv
// Circular buffer byte-offset register: clear, modulo-step increment and a
// registered one-cycle pulse whenever the offset wraps back to zero.
module ram_addr_wrap #(
    parameter int BUF_BYTES = 8192,
    parameter int STEP      = 2,
    parameter int OFF_WID   = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [OFF_WID-1:0] offset_o,
    output logic               wrap_o
);
    import ram_shim_pkg::*;

    localparam logic [OFF_WID-1:0] LAST_OFF = OFF_WID'(BUF_BYTES - STEP);
    localparam logic [OFF_WID-1:0] STEP_OFF = OFF_WID'(STEP);

    logic [OFF_WID-1:0] offset_q, offset_d;
    logic               wrap_q, wrap_d;

    always_comb begin
        offset_d = offset_q;
        wrap_d   = 1'b0;
        if (clr_i) begin
            offset_d = '0;
        end else if (inc_i) begin
            // Exact compare keeps the wrap correct for non power-of-two buffers.
            if (offset_q == LAST_OFF) begin
                offset_d = '0;
                wrap_d   = 1'b1;
            end else begin
                offset_d = offset_q + STEP_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            offset_q <= offset_d;
            wrap_q   <= wrap_d;
        end
    end

    assign offset_o = offset_q;
    assign wrap_o   = wrap_q;

endmodule

// File: rtl/ram_stream_shim.sv
// Streams sign-extended samples into a circular RAM buffer one DMA word at a
// time. Optional sample counter and wrap pulse via RAM_STREAM_SHIM_COUNT_EN.
module ram_stream_shim #(
    parameter logic [31:0] BASE_ADDR = 32'h1000000,
    parameter int          BUF_BYTES = 8192,
    parameter int          DAT_WID   = 24,
    parameter int          RAM_WORD  = 16,
    parameter int          RAM_WID   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DAT_WID-1:0]  data,
    input  logic                commit,
    input  logic                rewind,
    output logic                finished,
    output logic                busy,
    output logic [RAM_WORD-1:0] word,
    output logic [RAM_WID-1:0]  addr,
    output logic                write,
    input  logic                valid
`ifdef RAM_STREAM_SHIM_COUNT_EN
    ,
    output logic [31:0]         sample_cnt,
    output logic                wrapped
`endif
);
    import ram_shim_pkg::*;

    localparam int WORDS    = ceil_div(DAT_WID, RAM_WORD);
    localparam int WBYTES   = RAM_WORD / 8;
    localparam int OFF_WID  = clog2(BUF_BYTES);
    localparam int SREG_WID = WORDS * RAM_WORD;
    localparam int IDX_WID  = (WORDS > 1) ? clog2(WORDS) : 1;
    localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(WORDS - 1);

    state_t                state_q, state_d;
    logic [SREG_WID-1:0]   sreg_q, sreg_d;
    logic [RAM_WORD-1:0]   word_q, word_d;
    logic                  write_q, write_d;
    logic                  finished_q, finished_d;
    logic [IDX_WID-1:0]    idx_q, idx_d;
    logic                  off_clr, off_inc;
    logic [OFF_WID-1:0]    offset;
    logic                  wrap_pulse;
    logic [SREG_WID-1:0]   data_ext;

    generate
        for (genvar gi = 0; gi < SREG_WID; gi++) begin : g_ext
            if (gi < DAT_WID) begin : g_bit
                assign data_ext[gi] = data[gi];
            end else begin : g_sign
                assign data_ext[gi] = data[DAT_WID-1];
            end
        end
    endgenerate

    ram_addr_wrap #(
        .BUF_BYTES (BUF_BYTES),
        .STEP      (WBYTES),
        .OFF_WID   (OFF_WID)
    ) u_addr (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (off_clr),
        .inc_i    (off_inc),
        .offset_o (offset),
        .wrap_o   (wrap_pulse)
    );

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        word_d     = word_q;
        write_d    = write_q;
        finished_d = finished_q;
        idx_d      = idx_q;
        off_clr    = 1'b0;
        off_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                // Rewind wins; a held commit is then taken on the next cycle.
                if (rewind) begin
                    off_clr = 1'b1;
                end else if (commit) begin
                    sreg_d  = data_ext;
                    word_d  = data_ext[RAM_WORD-1:0];
                    write_d = 1'b1;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (valid) begin
                    write_d = 1'b0;
                    off_inc = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        finished_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                word_d  = sreg_q[int'(idx_q) * RAM_WORD +: RAM_WORD];
                write_d = 1'b1;
                state_d = WRITE;
            end
            DONE: begin
                if (!commit) begin
                    finished_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            word_q     <= '0;
            write_q    <= 1'b0;
            finished_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            word_q     <= word_d;
            write_q    <= write_d;
            finished_q <= finished_d;
            idx_q      <= idx_d;
        end
    end

    assign word     = word_q;
    assign write    = write_q;
    assign finished = finished_q;
    assign busy     = (state_q != IDLE);
    assign addr     = RAM_WID'(BASE_ADDR) + RAM_WID'(offset);

`ifdef RAM_STREAM_SHIM_COUNT_EN
    logic [31:0] sample_cnt_q, sample_cnt_d;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (state_q == WRITE && state_d == DONE) begin
            sample_cnt_d = sample_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign wrapped    = wrap_pulse;
`else
    logic wrap_unused;
    assign wrap_unused = wrap_pulse;
`endif

endmodule

// File: tb/tb_ram_stream_shim.sv
// Directed scoreboard bench for ram_stream_shim: a default 24-bit instance and
// a 40-bit instance with a 12-byte buffer that wraps mid-stream.
module tb_ram_stream_shim;

    localparam logic [31:0] BASE  = 32'h1000000;
    localparam int          BUF_A = 8192;
    localparam int          BUF_B = 12;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] word;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, commit_a, rewind_a, valid_a;
    logic [23:0] data_a;
    logic        finished_a, busy_a, write_a;
    logic [15:0] word_a;
    logic [31:0] addr_a;

    logic        rst_b, commit_b, rewind_b, valid_b;
    logic [39:0] data_b;
    logic        finished_b, busy_b, write_b;
    logic [15:0] word_b;
    logic [31:0] addr_b;

`ifdef RAM_STREAM_SHIM_COUNT_EN
    logic [31:0] cnt_out_a, cnt_out_b;
    logic        wrapped_a, wrapped_b;
`endif

    ram_stream_shim u_dut_a (
        .clk(clk), .rst(rst_a), .data(data_a), .commit(commit_a), .rewind(rewind_a),
        .finished(finished_a), .busy(busy_a), .word(word_a), .addr(addr_a),
        .write(write_a), .valid(valid_a)
`ifdef RAM_STREAM_SHIM_COUNT_EN
        , .sample_cnt(cnt_out_a), .wrapped(wrapped_a)
`endif
    );

    ram_stream_shim #(.BUF_BYTES(BUF_B), .DAT_WID(40)) u_dut_b (
        .clk(clk), .rst(rst_b), .data(data_b), .commit(commit_b), .rewind(rewind_b),
        .finished(finished_b), .busy(busy_b), .word(word_b), .addr(addr_b),
        .write(write_b), .valid(valid_b)
`ifdef RAM_STREAM_SHIM_COUNT_EN
        , .sample_cnt(cnt_out_b), .wrapped(wrapped_b)
`endif
    );

    logic        sel_b;
    logic        s_finished, s_busy, s_write;
    logic [15:0] s_word;
    logic [31:0] s_addr;
    assign s_finished = sel_b ? finished_b : finished_a;
    assign s_busy     = sel_b ? busy_b     : busy_a;
    assign s_write    = sel_b ? write_b    : write_a;
    assign s_word     = sel_b ? word_b     : word_a;
    assign s_addr     = sel_b ? addr_b     : addr_a;
`ifdef RAM_STREAM_SHIM_COUNT_EN
    logic        s_wrapped;
    logic [31:0] s_cnt;
    assign s_wrapped = sel_b ? wrapped_b : wrapped_a;
    assign s_cnt     = sel_b ? cnt_out_b : cnt_out_a;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   off_a   = 0;
    int   off_b   = 0;
    int   cnt_a   = 0;
    int   cnt_b   = 0;
    exp_t sbq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_valid(input logic v);
        if (sel_b) valid_b = v; else valid_a = v;
    endtask

    task automatic drive_commit(input logic c);
        if (sel_b) commit_b = c; else commit_a = c;
    endtask

    // One full sample: lat = write cycles before valid, vhold = valid held high,
    // rew = rewind together with commit, early = drop commit before finished.
    task automatic run_sample(input logic b, input logic [39:0] d, input int lat,
                              input bit vhold, input bit rew, input bit early);
        logic [47:0] ext;
        int          nw, off, bufb, cyc, wcnt;
        bit          got_fin, exp_low, exp_wrap;
        exp_t        e;
        sel_b = b;
        nw    = b ? 3 : 2;
        bufb  = b ? BUF_B : BUF_A;
        off   = b ? off_b : off_a;
        ext   = b ? {{8{d[39]}}, d} : {{24{d[23]}}, d[23:0]};
        @(negedge clk);
        if (b) begin data_b = d; rewind_b = rew; end
        else begin data_a = d[23:0]; rewind_a = rew; end
        drive_commit(1'b1);
        if (rew) begin
            @(negedge clk);
            rewind_a = 1'b0;
            rewind_b = 1'b0;
            check("rewind_no_write", {63'd0, s_write}, 64'd0);
            check("rewind_addr", {32'd0, s_addr}, {32'd0, BASE});
            off = 0;
        end
        for (int k = 0; k < nw; k++) begin
            e.addr = BASE + off;
            e.word = ext[k*16 +: 16];
            sbq.push_back(e);
            off = (off + 2) % bufb;
        end
        if (b) off_b = off; else off_a = off;
        cyc = 0; wcnt = 0; got_fin = 0; exp_low = 0; exp_wrap = 0;
        while (!got_fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                data_a = 24'h5A5A5A;
                data_b = 40'hA5A5A5A5A5;
            end
            if (early && cyc == 2) drive_commit(1'b0);
            if (exp_low) check("gap_write_low", {63'd0, s_write}, 64'd0);
            exp_low = 0;
`ifdef RAM_STREAM_SHIM_COUNT_EN
            check("wrapped", {63'd0, s_wrapped}, {63'd0, exp_wrap});
`endif
            exp_wrap = 0;
            if (s_finished) begin
                got_fin = 1;
                drive_valid(1'b0);
            end else if (s_write) begin
                if (wcnt == lat) begin
                    drive_valid(1'b1);
                    check("sbq_nonempty", {63'd0, sbq.size() != 0}, 64'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check("word", {48'd0, s_word}, {48'd0, e.word});
                        check("addr", {32'd0, s_addr}, {32'd0, e.addr});
                        $display("[TB] %s wrote %04h @ %08h", b ? "B" : "A", s_word, s_addr);
                        exp_wrap = (e.addr == BASE + bufb - 2);
                    end
                    exp_low = 1;
                    wcnt = 0;
                end else begin
                    drive_valid(vhold);
                    wcnt++;
                end
            end else begin
                drive_valid(vhold);
            end
        end
        check("finished_seen", {63'd0, got_fin}, 64'd1);
        check("all_words_written", 64'(sbq.size()), 64'd0);
        if (vhold) check("finish_latency", 64'(cyc), 64'd4);
        sbq.delete();
        drive_commit(1'b0);
        if (b) cnt_b++; else cnt_a++;
        @(negedge clk);
        check("finished_drop", {63'd0, s_finished}, 64'd0);
        check("idle_not_busy", {63'd0, s_busy}, 64'd0);
`ifdef RAM_STREAM_SHIM_COUNT_EN
        check("sample_cnt", {32'd0, s_cnt}, 64'(b ? cnt_b : cnt_a));
`endif
    endtask

    initial begin
        sel_b = 1'b0;
        rst_a = 1'b1; commit_a = 1'b0; rewind_a = 1'b0; valid_a = 1'b0; data_a = '0;
        rst_b = 1'b1; commit_b = 1'b0; rewind_b = 1'b0; valid_b = 1'b0; data_b = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        check("rst_a_finished", {63'd0, finished_a}, 64'd0);
        check("rst_a_busy", {63'd0, busy_a}, 64'd0);
        check("rst_a_write", {63'd0, write_a}, 64'd0);
        check("rst_a_word", {48'd0, word_a}, 64'd0);
        check("rst_a_addr", {32'd0, addr_a}, {32'd0, BASE});
        check("rst_b_write", {63'd0, write_b}, 64'd0);
        check("rst_b_addr", {32'd0, addr_b}, {32'd0, BASE});

        // 24-bit negative sample, slow RAM, then follow-on samples.
        run_sample(1'b0, 40'h800123, 2, 0, 0, 0);
        run_sample(1'b0, 40'h123456, 2, 0, 0, 0);
        run_sample(1'b0, 40'h654321, 1, 0, 0, 1);
        // Rewind and commit together with offset at 12.
        run_sample(1'b0, 40'hABCDEF, 1, 0, 1, 0);
        // valid held high throughout.
        run_sample(1'b0, 40'h00FFFF, 0, 1, 0, 0);

        // Reset while the second word is being presented.
        sel_b = 1'b0;
        @(negedge clk);
        data_a = 24'h0F0F0F;
        commit_a = 1'b1;
        @(negedge clk);
        check("rst_test_w0_write", {63'd0, write_a}, 64'd1);
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        @(negedge clk);
        check("rst_test_w1_write", {63'd0, write_a}, 64'd1);
        check("rst_test_w1_addr", {32'd0, addr_a}, {32'd0, BASE + off_a + 2});
        rst_a = 1'b1;
        commit_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        check("midrst_write", {63'd0, write_a}, 64'd0);
        check("midrst_busy", {63'd0, busy_a}, 64'd0);
        check("midrst_finished", {63'd0, finished_a}, 64'd0);
        check("midrst_addr", {32'd0, addr_a}, {32'd0, BASE});
        $display("[TB] A reset mid-sample");
        off_a = 0;
        cnt_a = 0;
        run_sample(1'b0, 40'h7FFFFF, 0, 0, 0, 0);

        // 40-bit samples into a 12-byte buffer: second sample ends on the wrap.
        run_sample(1'b1, 40'h7F12345678, 1, 0, 0, 0);
        run_sample(1'b1, 40'h8000000001, 0, 0, 0, 0);
        run_sample(1'b1, 40'hFFFFFFFFFE, 2, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
